uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (legal 5..8).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, meaning sample ticks per bit (even, 8..32).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning receive FIFO entries (power of 2, 2..64).
REQ-004 SHALL have parameter DIV_W, default 16, meaning width of baud_div.
REQ-005 SHALL have port clk  in  1  the single clock; all logic rises on it.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port rx  in  1  asynchronous serial line, idle high.
REQ-008 SHALL have port baud_div  in  DIV_W  clk cycles per sample tick, minus 1.
REQ-009 SHALL have port parity_en  in  1  expect a parity bit after the data bits.
REQ-010 SHALL have port parity_odd  in  1  1 = odd parity, 0 = even parity.
REQ-011 SHALL have port rd_en  in  1  pop the FIFO head.
REQ-012 SHALL have port rd_data  out  DATA_BITS  FIFO head, valid while empty=0.
REQ-013 SHALL have port empty  out  1, full  out  1, count  out  $clog2(FIFO_DEPTH)+1  FIFO status.
REQ-014 SHALL have port err_clr  in  1  clears all sticky error flags.
REQ-015 SHALL have ports frame_err, parity_err, overrun  out  1 each  sticky error flags.

Function
REQ-016 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-017 SHALL generate a one-cycle sample tick every baud_div+1 clks; the tick counter restarts on every IDLE->START transition.
REQ-018 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-019 IDLE->START on a synchronized falling edge of rx.
REQ-020 In START, at tick OVERSAMPLE/2: rx=0 -> DATA; rx=1 -> IDLE (glitch, no flag, nothing pushed).
REQ-021 In DATA, SHALL sample every OVERSAMPLE ticks, LSB first, DATA_BITS samples; then -> PARITY if parity is enabled, else -> STOP.
REQ-022 In PARITY, SHALL sample one bit and compare it against the XOR of the data bits (inverted when parity_odd=1).
REQ-023 In STOP, SHALL sample once: rx=0 -> set frame_err and discard the byte; a parity mismatch -> set parity_err and discard the byte; otherwise push. Next state is IDLE in all cases.
REQ-024 A push SHALL occur on the cycle after the stop-bit sample.
REQ-025 A push while full and rd_en=0 SHALL drop the new byte and set overrun; a push while full with rd_en=1 SHALL be accepted, leaving count unchanged.
REQ-026 rd_data SHALL be show-ahead: the head is visible while empty=0, and the next entry is visible on the cycle after rd_en.
REQ-027 rd_en while empty SHALL be ignored, with no pointer or count change.
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH; full SHALL equal (count==FIFO_DEPTH).
REQ-029 err_clr SHALL clear the flags on the next edge; a same-cycle set SHALL win over err_clr.

Reset
REQ-030 On reset: state IDLE, synchronizer flops 1, tick counter 0, pointers 0, count 0, empty 1, full 0, all error flags 0, rd_data 0.
REQ-031 Reset mid-frame SHALL abort the frame with no push and no flag.

Configuration
REQ-032 With UART_RX_PARITY_EN defined, parity SHALL be supported per REQ-021..023.
REQ-033 Without UART_RX_PARITY_EN, the PARITY state and its checker SHALL be absent, parity_en and parity_odd SHALL be ignored, and parity_err SHALL be tied to 0.

Structure
REQ-034 Package uart_pkg SHALL hold the rx state enum and the default DATA_BITS, OVERSAMPLE and FIFO_DEPTH constants.
REQ-035 The FIFO SHALL be sub-module uart_sync_fifo (parameters WIDTH, DEPTH); the deserializer lives in uart_rx_fifo.

Verification
REQ-036 Default parameters, baud_div=0 (16 clk/bit), frame 0x5A 8N1 -> rd_data=0x5A, count=1, empty=0, no flags.
REQ-037 A 4-clk low pulse on idle rx -> no push, state back to IDLE, count=0.
REQ-038 Macro defined, parity_en=1, parity_odd=0: 0x5A with parity 0 -> pushed; 0x5A with parity 1 -> parity_err=1, count unchanged.
REQ-039 Stop bit driven 0 on 0x33 -> frame_err=1, no push; err_clr=1 for one cycle -> frame_err=0.
REQ-040 Nine frames 0x01..0x09 with rd_en=0 -> full=1, count=8, overrun=1, head=0x01; a ninth push with rd_en=1 -> accepted, count=8.
REQ-041 Reset asserted during DATA bit 3, then frame 0xA5 -> only 0xA5 in the FIFO, count=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver slice: rx state encoding and
// default sizing constants. UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_FIFO_DEPTH = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Read-side bus of the UART receiver: FIFO pop/status and sticky error flags.
// master = consumer of received bytes, slave = the receiver itself.
interface uart_rx_fifo_if import uart_pkg::*; #(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) ();

    logic                          rd_en;
    logic [DATA_BITS-1:0]          rd_data;
    logic                          empty;
    logic                          full;
    logic [$clog2(FIFO_DEPTH):0]   count;
    logic                          err_clr;
    logic                          frame_err;
    logic                          parity_err;
    logic                          overrun;

    modport master (
        output rd_en, err_clr,
        input  rd_data, empty, full, count, frame_err, parity_err, overrun
    );

    modport slave (
        input  rd_en, err_clr,
        output rd_data, empty, full, count, frame_err, parity_err, overrun
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO. A write while full is accepted only when a
// read happens in the same cycle; a read while empty is ignored.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_rd;
    logic             do_wr;

    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    // Head is forced to zero while empty so the output is defined out of reset.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset since empty masks the head.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with oversampled deserializer feeding a show-ahead FIFO.
// Optional parity checking is compiled in with UART_RX_PARITY_EN.
module uart_rx_fifo import uart_pkg::*; #(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int DIV_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic              parity_en,
    input  logic              parity_odd,
    uart_rx_fifo_if.slave     bus
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE/2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    rx_state_t            state, state_nxt;
    logic                 rx_meta, rx_sync, rx_prev;
    logic                 fall;
    logic [DIV_W-1:0]     div_cnt;
    logic                 tick;
    logic [TICK_W-1:0]    tick_cnt;
    logic                 smp;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 data_smp, stop_smp;
    logic                 par_bad;
    logic                 push_vld_p1;
    logic [DATA_BITS-1:0] push_data_p1;
    logic                 fe_set, pe_set, ov_set;
    logic                 frame_err_q, overrun_q;

    assign fall = rx_prev && !rx_sync;
    assign tick = (div_cnt == baud_div);
    // START samples mid-bit after half a bit period; later states a full bit apart.
    assign smp  = tick && (tick_cnt == ((state == START) ? HALF_LAST : FULL_LAST));

    // Two-flop synchronizer plus one delay flop for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Baud divider; restarted at frame start so the sample phase tracks the start edge.
    always_ff @(posedge clk) begin
        if (reset || (state == IDLE && fall) || tick) div_cnt <= '0;
        else                                          div_cnt <= div_cnt + 1'b1;
    end

    // Oversample tick counter within the current bit.
    always_ff @(posedge clk) begin
        if (reset || state == IDLE || smp) tick_cnt <= '0;
        else if (tick)                     tick_cnt <= tick_cnt + 1'b1;
    end

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

`ifdef UART_RX_PARITY_EN
    logic par_smp;
`endif

    // Next-state logic and sample strobes.
    always_comb begin
        state_nxt = state;
        data_smp  = 1'b0;
        stop_smp  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_smp   = 1'b0;
`endif
        case (state)
            IDLE:  if (fall) state_nxt = START;
            START: if (smp)  state_nxt = rx_sync ? IDLE : DATA;
            DATA: begin
                if (smp) begin
                    data_smp = 1'b1;
                    if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = parity_en ? PARITY : STOP;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (smp) begin
                    par_smp   = 1'b1;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (smp) begin
                    stop_smp  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Data bit counter, LSB-first shift register.
    always_ff @(posedge clk) begin
        if (reset || state != DATA) bit_cnt <= '0;
        else if (data_smp)          bit_cnt <= bit_cnt + 1'b1;
    end

    // Shift register fills from the top so the first bit ends up in bit 0.
    always_ff @(posedge clk) begin
        if (data_smp) shreg <= {rx_sync, shreg[DATA_BITS-1:1]};
    end

`ifdef UART_RX_PARITY_EN
    // Parity check result, held until the stop bit decides the frame.
    always_ff @(posedge clk) begin
        if (reset || state == IDLE) par_bad <= 1'b0;
        else if (par_smp)           par_bad <= rx_sync ^ (^shreg) ^ parity_odd;
    end
`else
    logic unused_parity;
    assign unused_parity = parity_en ^ parity_odd;
    assign par_bad       = 1'b0;
`endif

    assign fe_set = stop_smp && !rx_sync;
    assign pe_set = stop_smp && rx_sync && par_bad;
    assign ov_set = push_vld_p1 && bus.full && !bus.rd_en;

    // Stop-bit decision registered into the push stage one cycle later.
    always_ff @(posedge clk) begin
        if (reset) push_vld_p1 <= 1'b0;
        else       push_vld_p1 <= stop_smp && rx_sync && !par_bad;
    end

    // Push payload captured alongside the push valid.
    always_ff @(posedge clk) begin
        if (stop_smp) push_data_p1 <= shreg;
    end

    // Sticky error flags; a set in the same cycle wins over err_clr.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (fe_set)           frame_err_q <= 1'b1;
            else if (bus.err_clr) frame_err_q <= 1'b0;
            if (ov_set)           overrun_q   <= 1'b1;
            else if (bus.err_clr) overrun_q   <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_err_q;
    // Sticky parity error flag.
    always_ff @(posedge clk) begin
        if (reset)            parity_err_q <= 1'b0;
        else if (pe_set)      parity_err_q <= 1'b1;
        else if (bus.err_clr) parity_err_q <= 1'b0;
    end
    assign bus.parity_err = parity_err_q;
`else
    logic unused_pe;
    assign unused_pe      = pe_set;
    assign bus.parity_err = 1'b0;
`endif

    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_vld_p1),
        .wr_data (push_data_p1),
        .rd_en   (bus.rd_en),
        .rd_data (bus.rd_data),
        .empty   (bus.empty),
        .full    (bus.full),
        .count   (bus.count)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized bench for uart_rx_fifo with a frame-level reference
// model (queue of bytes plus sticky flags). Honors UART_RX_PARITY_EN.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DB    = 8;
    localparam int OS    = 16;
    localparam int DEPTH = 8;
    localparam int DW    = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_SUP = 1'b1;
`else
    localparam bit PAR_SUP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          rx;
    logic [DW-1:0] baud_div;
    logic          parity_en;
    logic          parity_odd;

    uart_rx_fifo_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(
        .DATA_BITS  (DB),
        .OVERSAMPLE (OS),
        .FIFO_DEPTH (DEPTH),
        .DIV_W      (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .baud_div   (baud_div),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    bit m_fe, m_pe, m_ov;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".count"}, 32'(bus.count), 32'(q.size()));
        chk({tag, ".empty"}, 32'(bus.empty), 32'(q.size() == 0));
        chk({tag, ".full"}, 32'(bus.full), 32'(q.size() == DEPTH));
        chk({tag, ".frame_err"}, 32'(bus.frame_err), 32'(m_fe));
        chk({tag, ".parity_err"}, 32'(bus.parity_err), 32'(m_pe));
        chk({tag, ".overrun"}, 32'(bus.overrun), 32'(m_ov));
        if (q.size() > 0) chk({tag, ".head"}, 32'(bus.rd_data), 32'(q[0]));
    endtask

    // Frame-level rules: stop error, then parity error, then push / overrun.
    task automatic model_frame(input logic [7:0] d, input bit par_sent, input bit par_bit,
                               input bit stop_bit, input bit rd_hit, input bit clr_hit);
        bit full_b;
        if (clr_hit) begin m_fe = 0; m_pe = 0; m_ov = 0; end
        full_b = (q.size() == DEPTH);
        if (rd_hit && q.size() > 0) void'(q.pop_front());
        if (!stop_bit) m_fe = 1;
        else if (par_sent && (par_bit != ((^d) ^ parity_odd))) m_pe = 1;
        else if (full_b && !rd_hit) m_ov = 1;
        else q.push_back(d);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_bit, input bit stop_bit,
                              input int rd_at, input int clr_at);
        int  len;
        bit  par_sent;
        int  nb;
        int  b;
        len      = OS * (int'(baud_div) + 1);
        par_sent = PAR_SUP && parity_en;
        nb       = 10 + int'(par_sent);
        for (int c = 0; c < nb * len; c++) begin
            @(negedge clk);
            b = c / len;
            if (b == 0)                    rx = 1'b0;
            else if (b <= 8)               rx = d[b-1];
            else if (par_sent && b == 9)   rx = par_bit;
            else                           rx = stop_bit;
            bus.rd_en   = (c == rd_at);
            bus.err_clr = (c == clr_at);
        end
        @(negedge clk);
        rx = 1'b1; bus.rd_en = 1'b0; bus.err_clr = 1'b0;
        repeat (2 * len) @(negedge clk);
        model_frame(d, par_sent, par_bit, stop_bit, rd_at >= 0, clr_at >= 0);
    endtask

    task automatic pop(input string tag);
        if (q.size() > 0) chk({tag, ".pop_head"}, 32'(bus.rd_data), 32'(q[0]));
        @(negedge clk); bus.rd_en = 1'b1;
        @(negedge clk); bus.rd_en = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic clear_errs();
        @(negedge clk); bus.err_clr = 1'b1;
        @(negedge clk); bus.err_clr = 1'b0;
        m_fe = 0; m_pe = 0; m_ov = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1; rx = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        q.delete(); m_fe = 0; m_pe = 0; m_ov = 0;
    endtask

    logic [7:0] rd_byte;
    bit         pb, sb;

    initial begin
        reset = 1'b1; rx = 1'b1; baud_div = '0; parity_en = 1'b0; parity_odd = 1'b0;
        bus.rd_en = 1'b0; bus.err_clr = 1'b0;

        // Reset state
        do_reset();
        @(negedge clk);
        check_model("reset");
        chk("reset.rd_data", 32'(bus.rd_data), 32'h0);
        chk("reset.state", 32'(dut.state), 32'(IDLE));

        // Single 8N1 frame
        send_frame(8'h5A, 1'b0, 1'b1, -1, -1);
        chk("frame5a.rd_data", 32'(bus.rd_data), 32'h5A);
        chk("frame5a.count", 32'(bus.count), 32'd1);
        check_model("frame5a");
        pop("frame5a");
        @(negedge clk);
        check_model("after_pop");

        // Pop on empty is ignored
        pop("empty_pop");
        @(negedge clk);
        chk("empty_pop.count", 32'(bus.count), 32'd0);
        chk("empty_pop.empty", 32'(bus.empty), 32'd1);

        // Short glitch on idle line
        @(negedge clk); rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch.count", 32'(bus.count), 32'd0);
        chk("glitch.state", 32'(dut.state), 32'(IDLE));
        check_model("glitch");

`ifdef UART_RX_PARITY_EN
        // Even parity: good then bad parity bit
        parity_en = 1'b1; parity_odd = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b1, -1, -1);
        chk("par_good.count", 32'(bus.count), 32'd1);
        chk("par_good.parity_err", 32'(bus.parity_err), 32'd0);
        send_frame(8'h5A, 1'b1, 1'b1, -1, -1);
        chk("par_bad.parity_err", 32'(bus.parity_err), 32'd1);
        chk("par_bad.count", 32'(bus.count), 32'd1);
        check_model("parity");
`else
        // Parity inputs have no effect when parity support is absent
        parity_en = 1'b1; parity_odd = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b1, -1, -1);
        chk("nopar.count", 32'(bus.count), 32'd1);
        chk("nopar.parity_err", 32'(bus.parity_err), 32'd0);
        check_model("nopar");
`endif
        pop("par_pop");
        clear_errs();
        parity_en = 1'b0; parity_odd = 1'b0;

        // Stop bit low -> framing error, then clear
        send_frame(8'h33, 1'b0, 1'b0, -1, -1);
        chk("frame_err.set", 32'(bus.frame_err), 32'd1);
        chk("frame_err.count", 32'(bus.count), 32'd0);
        clear_errs();
        @(negedge clk);
        chk("frame_err.clr", 32'(bus.frame_err), 32'd0);

        // Fill, overrun (err_clr in the same cycle loses), then push with rd_en
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b1, -1, -1);
        send_frame(8'h09, 1'b0, 1'b1, -1, 155);
        chk("ovr.full", 32'(bus.full), 32'd1);
        chk("ovr.count", 32'(bus.count), 32'd8);
        chk("ovr.overrun", 32'(bus.overrun), 32'd1);
        chk("ovr.head", 32'(bus.rd_data), 32'h01);
        check_model("ovr");
        clear_errs();
        send_frame(8'h0A, 1'b0, 1'b1, 155, -1);
        chk("rdpush.count", 32'(bus.count), 32'd8);
        chk("rdpush.overrun", 32'(bus.overrun), 32'd0);
        chk("rdpush.head", 32'(bus.rd_data), 32'h02);
        check_model("rdpush");

        // Reset during data bit 3 aborts the frame
        for (int c = 0; c < 72; c++) begin
            @(negedge clk);
            rd_byte = 8'h3C;
            if (c / OS == 0) rx = 1'b0;
            else             rx = rd_byte[c/OS - 1];
        end
        do_reset();
        repeat (3 * OS) @(negedge clk);
        chk("midreset.rd_data", 32'(bus.rd_data), 32'h0);
        chk("midreset.state", 32'(dut.state), 32'(IDLE));
        check_model("midreset");
        send_frame(8'hA5, 1'b0, 1'b1, -1, -1);
        chk("midreset.count", 32'(bus.count), 32'd1);
        chk("midreset.head", 32'(bus.rd_data), 32'hA5);
        check_model("after_midreset");

        // Randomized frames against the model
        for (int i = 0; i < 14; i++) begin
            baud_div   = DW'($urandom_range(0, 2));
            parity_en  = 1'($urandom_range(0, 1));
            parity_odd = 1'($urandom_range(0, 1));
            rd_byte    = 8'($urandom);
            pb         = (^rd_byte) ^ parity_odd ^ ($urandom_range(0, 3) == 0);
            sb         = ($urandom_range(0, 5) != 0);
            send_frame(rd_byte, pb, sb, -1, -1);
            check_model("rand");
            if ($urandom_range(0, 2) == 0) pop("rand");
            if ($urandom_range(0, 3) == 0) clear_errs();
        end
        @(negedge clk);
        check_model("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
